instr_prefetch_queue: RTL and testbench
=======================================

// Module: instr_prefetch_queue
// PURPOSE
//  Instruction prefetch buffer between imem and stage_decode; replaces direct imem->decode path.
//  Issues sequential imem reads from its own fetch PC, buffers {pc,instr} pairs, hands them to decode
//  over valid/ready. Flushes and restarts on jump/branch redirect from the mem stage.
// PARAMETERS
//  DEPTH     4            queue entries; power of two, >=2
//  RESET_PC  32'h0        first fetch address after reset
// PORTS
//  clk             in   1           clock, all state on rising edge
//  reset           in   1           asynchronous, active-high reset
//  redirect_i      in   1           taken jump/branch; one-cycle pulse
//  redirect_pc_i   in   INSTR_SIZE  redirect target
//  imem_addr_o     out  INSTR_SIZE  imem read address
//  imem_op_en_o    out  1           imem read request
//  imem_rd_wr_o    out  1           imem op type; constant 0 (read)
//  imem_rd_data_i  in   WD_SIZE     imem read data, valid 1 cycle after op_en
//  instr_valid_o   out  1           head entry valid to decode
//  instr_o         out  INSTR_SIZE  head instruction
//  pc_o            out  INSTR_SIZE  head pc
//  instr_ready_i   in   1           decode accepts head this cycle
//  misalign_o      out  1           sticky: redirect target not word aligned
// BEHAVIOUR
//  Reset: all outputs 0; fetch_pc=RESET_PC; count=0; wr/rd ptr=0; inflight=0; state=BOOT.
//  FSM: BOOT -> RUN next cycle (no issue in BOOT).
//   RUN: redirect with redirect_pc_i[1:0]!=0 -> HALT, misalign_o=1.
//   HALT: no issue; stays until aligned redirect -> RUN, misalign_o cleared.
//  Issue (RUN only): op_en=1, addr=fetch_pc when count+inflight<DEPTH (credit check, pops this
//   cycle not counted); fetch_pc+=4, wraps mod 2^INSTR_SIZE; inflight<=1, pc of request kept.
//  Response: cycle after issue, {req_pc,imem_rd_data_i} pushed at wr_ptr unless killed.
//  Pop: instr_valid_o&instr_ready_i -> rd_ptr++. Push and pop same cycle: count unchanged.
//  Pointers wrap at DEPTH. Overflow impossible by credit rule; assertion on push while full.
//  Redirect (highest priority): same cycle clear count/ptrs, instr_valid_o=0 next cycle, kill
//   in-flight response, fetch_pc<=redirect_pc_i; no issue in redirect cycle; first new issue next cycle.
//  instr_ready_i ignored when instr_valid_o=0. Outputs hold stable while valid&!ready.
//  Steady state with ready=1: one instr per cycle after fill.
//  Reset mid-operation: immediate return to reset values, in-flight response dropped.
// CONFIGURATION
//  FETCH_Q_BYPASS_EN defined: when queue empty and response arrives unkilled, instr_valid_o/
//   instr_o/pc_o driven combinationally from response; if accepted, not written to queue.
//   Issue->valid latency 1 cycle.
//  Undefined: response always enqueued; issue->instr_valid_o latency 2 cycles.
// STRUCTURE
//  PARAMS_pkg additions: typedef struct packed {logic[INSTR_SIZE-1:0] pc; logic[INSTR_SIZE-1:0] instr;}
//   fq_entry_t; typedef enum logic[1:0] {FQ_BOOT,FQ_RUN,FQ_HALT} fq_state_t; localparam INSTR_BYTES=4.
//  One sub-module: fq_storage (DEPTH x fq_entry_t register array, write port, async read port).
//  Control FSM, credit, kill and pointer logic stay in this module.
// TESTING
//  1 Reset release, ready=1, imem returns addr as data -> pc_o 0,4,8,C one per cycle after fill.
//  2 ready=0 for 10 cycles -> exactly DEPTH=4 issues, count=4, op_en=0, outputs stable at pc 0.
//  3 Redirect to 0x40 while full with read in flight -> queue empty next cycle, stale data never
//    seen, next pc_o = 0x40 then 0x44.
//  4 Redirect to 0x42 -> misalign_o=1, no op_en; then redirect 0x80 -> misalign_o=0, pc_o=0x80.
//  5 Random ready toggling 1000 cycles vs reference model -> pc sequence gapless, no dup/drop.
//  6 reset pulse mid-fill -> outputs 0, next fetch at RESET_PC; bypass build: 1 cycle latency.

Source files
------------

// File: rtl/instr_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package instr_prefetch_queue_pkg;

  localparam int unsigned INSTR_SIZE  = 32;
  localparam int unsigned WD_SIZE     = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [INSTR_SIZE-1:0] pc;
    logic [INSTR_SIZE-1:0] instr;
  } fq_entry_t;

  typedef enum logic [1:0] {FQ_BOOT, FQ_RUN, FQ_HALT} fq_state_t;

  function automatic logic is_word_aligned(input logic [INSTR_SIZE-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// Bundle of imem request/response, decode handshake and redirect signals for the prefetch queue.
interface instr_prefetch_queue_if;
  import instr_prefetch_queue_pkg::*;

  logic                  redirect_i;
  logic [INSTR_SIZE-1:0] redirect_pc_i;
  logic [INSTR_SIZE-1:0] imem_addr_o;
  logic                  imem_op_en_o;
  logic                  imem_rd_wr_o;
  logic [WD_SIZE-1:0]    imem_rd_data_i;
  logic                  instr_valid_o;
  logic [INSTR_SIZE-1:0] instr_o;
  logic [INSTR_SIZE-1:0] pc_o;
  logic                  instr_ready_i;
  logic                  misalign_o;

  modport master (
    input  redirect_i, redirect_pc_i, imem_rd_data_i, instr_ready_i,
    output imem_addr_o, imem_op_en_o, imem_rd_wr_o, instr_valid_o, instr_o, pc_o, misalign_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, imem_rd_data_i, instr_ready_i,
    input  imem_addr_o, imem_op_en_o, imem_rd_wr_o, instr_valid_o, instr_o, pc_o, misalign_o
  );

endinterface

// File: rtl/instr_prefetch_queue_fq_storage.sv
// DEPTH-entry {pc,instr} register file: one synchronous write port, one asynchronous read port.
module instr_prefetch_queue_fq_storage
  import instr_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  fq_entry_t                wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output fq_entry_t                rdata_o
);

  fq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue between imem and decode; flushes on redirect from the mem stage.
// Optional FETCH_Q_BYPASS_EN: an unkilled response into an empty queue is presented combinationally.
module instr_prefetch_queue
  import instr_prefetch_queue_pkg::*;
#(
  parameter int unsigned           DEPTH    = 4,
  parameter logic [INSTR_SIZE-1:0] RESET_PC = '0
) (
  input logic                    clk,
  input logic                    reset,
  instr_prefetch_queue_if.master bus
);

  localparam int unsigned     PtrW     = $clog2(DEPTH);
  localparam int unsigned     CntW     = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  fq_state_t             state_q, state_d;
  logic [INSTR_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [INSTR_SIZE-1:0] req_pc_q, req_pc_d;
  logic                  inflight_q, inflight_d;
  logic                  misalign_q, misalign_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;

  logic      redirect;
  logic      resp_live;
  logic      head_valid;
  logic      out_valid;
  logic      take;
  logic      pop;
  logic      push;
  logic      credit_ok;
  logic      issue;
  fq_entry_t head_entry;
  fq_entry_t resp_entry;
  fq_entry_t out_entry;

  // Handshake, credit and issue decisions
  always_comb begin
    redirect   = bus.redirect_i;
    resp_live  = inflight_q && !redirect;
    head_valid = (count_q != '0);
    resp_entry = '{pc: req_pc_q, instr: bus.imem_rd_data_i};
`ifdef FETCH_Q_BYPASS_EN
    out_valid  = head_valid || resp_live;
    out_entry  = (!head_valid && resp_live) ? resp_entry : head_entry;
`else
    out_valid  = head_valid;
    out_entry  = head_entry;
`endif
    take       = out_valid && bus.instr_ready_i && !redirect;
    pop        = take && head_valid;
    // A bypassed response that decode takes right away never occupies a slot.
    push       = resp_live && !(take && !head_valid);
    // Pops in this cycle do not free credit until the next one.
    credit_ok  = (count_q + CntW'(inflight_q)) < DepthCnt;
    issue      = (state_q == FQ_RUN) && !redirect && credit_ok;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect) begin
      fetch_pc_d = bus.redirect_pc_i;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + INSTR_SIZE'(INSTR_BYTES);
        req_pc_d   = fetch_pc_q;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    misalign_d = misalign_q;
    unique case (state_q)
      FQ_BOOT: state_d = FQ_RUN;
      FQ_RUN:  state_d = FQ_RUN;
      FQ_HALT: state_d = FQ_HALT;
      default: state_d = FQ_BOOT;
    endcase
    if (redirect) begin
      if (is_word_aligned(bus.redirect_pc_i)) begin
        state_d    = FQ_RUN;
        misalign_d = 1'b0;
      end else begin
        state_d    = FQ_HALT;
        misalign_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FQ_BOOT;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      misalign_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      misalign_q <= misalign_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  instr_prefetch_queue_fq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk     (clk),
    .reset   (reset),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (resp_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_entry)
  );

  assign bus.imem_addr_o   = issue ? fetch_pc_q : '0;
  assign bus.imem_op_en_o  = issue;
  assign bus.imem_rd_wr_o  = 1'b0;
  assign bus.instr_valid_o = out_valid;
  assign bus.instr_o       = out_entry.instr;
  assign bus.pc_o          = out_entry.pc;
  assign bus.misalign_o    = misalign_q;

  no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    !(push && (count_q == DepthCnt)));

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: cycle table, corner-case sequences and a random run vs a model.
module tb_instr_prefetch_queue;
  import instr_prefetch_queue_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_Q_BYPASS_EN
  localparam int   LAT = 1;
  localparam logic BYP = 1'b1;
`else
  localparam int   LAT = 2;
  localparam logic BYP = 1'b0;
`endif

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        ready     = 1'b0;
  logic        redir     = 1'b0;
  logic [31:0] redir_pc  = 32'h0;
  logic [31:0] imem_data = 32'h0;
  int          n_pass    = 0;
  int          n_total   = 0;

  instr_prefetch_queue_if bus ();

  assign bus.instr_ready_i  = ready;
  assign bus.redirect_i     = redir;
  assign bus.redirect_pc_i  = redir_pc;
  assign bus.imem_rd_data_i = imem_data;

  instr_prefetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // imem: data = ~addr, one cycle after the request
  always @(posedge clk) begin
    if (bus.imem_op_en_o) imem_data <= ~bus.imem_addr_o;
  end

  typedef struct {
    logic        rdy;
    logic        op_en;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(input logic rdy, input logic op_en, input logic [31:0] addr,
                              input logic valid, input logic [31:0] pc);
    vec_t v;
    v.rdy = rdy; v.op_en = op_en; v.addr = addr; v.valid = valid; v.pc = pc;
    return v;
  endfunction

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endfunction

  // Drive one cycle's inputs at the falling edge and settle before sampling.
  task automatic step(input bit wait_edge, input logic rdy, input logic rd,
                      input logic [31:0] tgt);
    if (wait_edge) @(negedge clk);
    ready = rdy; redir = rd; redir_pc = tgt;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; ready = 1'b0; redir = 1'b0; redir_pc = 32'h0;
    @(negedge clk);
    release_reset();
  endtask

  task automatic wait_head(input string name, input logic [31:0] exp_pc);
    int k = 0;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    while (!bus.instr_valid_o && k < 8) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      k++;
    end
    check({name, " valid"}, 32'(bus.instr_valid_o), 32'h1);
    check({name, " pc"}, bus.pc_o, exp_pc);
    check({name, " instr"}, bus.instr_o, ~exp_pc);
  endtask

  task automatic check_idle(input string name);
    check({name, " op_en"}, 32'(bus.imem_op_en_o), 32'h0);
    check({name, " addr"}, bus.imem_addr_o, 32'h0);
    check({name, " valid"}, 32'(bus.instr_valid_o), 32'h0);
    check({name, " pc"}, bus.pc_o, 32'h0);
    check({name, " instr"}, bus.instr_o, 32'h0);
    check({name, " misalign"}, 32'(bus.misalign_o), 32'h0);
  endtask

  initial begin
    // Cycle table after reset release: fill with ready=0, then drain with ready=1.
    for (int i = 0; i < 19; i++) vecs[i] = mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    vecs[0]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0);
    vecs[1]  = mk(1'b0, 1'b1, 32'h0,  1'b0, 32'h0);
    vecs[2]  = mk(1'b0, 1'b1, 32'h4,  BYP,  32'h0);
    vecs[3]  = mk(1'b0, 1'b1, 32'h8,  1'b1, 32'h0);
    vecs[4]  = mk(1'b0, 1'b1, 32'hC,  1'b1, 32'h0);
    vecs[13] = mk(1'b1, 1'b0, 32'h0,  1'b1, 32'h0);
    vecs[14] = mk(1'b1, 1'b1, 32'h10, 1'b1, 32'h4);
    vecs[15] = mk(1'b1, 1'b1, 32'h14, 1'b1, 32'h8);
    vecs[16] = mk(1'b1, 1'b1, 32'h18, 1'b1, 32'hC);
    vecs[17] = mk(1'b1, 1'b1, 32'h1C, 1'b1, 32'h10);
    vecs[18] = mk(1'b1, 1'b1, 32'h20, 1'b1, 32'h14);

    repeat (2) @(negedge clk);
    #1;
    check_idle("reset");
    release_reset();

    for (int i = 0; i < 19; i++) begin
      step(i != 0, vecs[i].rdy, 1'b0, 32'h0);
      check($sformatf("t1 c%0d op_en", i), 32'(bus.imem_op_en_o), 32'(vecs[i].op_en));
      if (vecs[i].op_en) check($sformatf("t1 c%0d addr", i), bus.imem_addr_o, vecs[i].addr);
      check($sformatf("t1 c%0d valid", i), 32'(bus.instr_valid_o), 32'(vecs[i].valid));
      if (vecs[i].valid) begin
        check($sformatf("t1 c%0d pc", i), bus.pc_o, vecs[i].pc);
        check($sformatf("t1 c%0d instr", i), bus.instr_o, ~vecs[i].pc);
      end
    end
    check("t1 rd_wr", 32'(bus.imem_rd_wr_o), 32'h0);

    // Redirect while full with a read in flight.
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    for (int c = 1; c <= 4; c++) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h40);
    check("t3 redirect op_en", 32'(bus.imem_op_en_o), 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("t3 flushed valid", 32'(bus.instr_valid_o), 32'h0);
    check("t3 reissue op_en", 32'(bus.imem_op_en_o), 32'h1);
    check("t3 reissue addr", bus.imem_addr_o, 32'h40);
    wait_head("t3 first", 32'h40);
    wait_head("t3 second", 32'h44);

    // Misaligned redirect halts fetching until an aligned one.
    step(1'b1, 1'b0, 1'b1, 32'h42);
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check($sformatf("t4 halt%0d misalign", c), 32'(bus.misalign_o), 32'h1);
      check($sformatf("t4 halt%0d op_en", c), 32'(bus.imem_op_en_o), 32'h0);
      check($sformatf("t4 halt%0d valid", c), 32'(bus.instr_valid_o), 32'h0);
    end
    step(1'b1, 1'b0, 1'b1, 32'h80);
    check("t4 redirect op_en", 32'(bus.imem_op_en_o), 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("t4 resume misalign", 32'(bus.misalign_o), 32'h0);
    check("t4 resume op_en", 32'(bus.imem_op_en_o), 32'h1);
    check("t4 resume addr", bus.imem_addr_o, 32'h80);
    wait_head("t4 head", 32'h80);

    // Asynchronous reset while halted, then again mid-fill.
    step(1'b1, 1'b0, 1'b1, 32'h46);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("t6 halted misalign", 32'(bus.misalign_o), 32'h1);
    #2 reset = 1'b1;
    #1;
    check_idle("t6 halt reset");
    release_reset();
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("t6 midfill op_en", 32'(bus.imem_op_en_o), 32'h1);
    #2 reset = 1'b1;
    #1;
    check_idle("t6 midfill reset");
    release_reset();
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("t6 boot op_en", 32'(bus.imem_op_en_o), 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("t6 first op_en", 32'(bus.imem_op_en_o), 32'h1);
    check("t6 first addr", bus.imem_addr_o, RESET_PC);
    for (int j = 1; j <= LAT; j++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check($sformatf("t6 lat%0d valid", j), 32'(bus.instr_valid_o), 32'(j == LAT));
    end
    check("t6 first pc", bus.pc_o, RESET_PC);
    check("t6 first instr", bus.instr_o, ~RESET_PC);

    // Random ready with occasional aligned redirects vs a transaction-level model:
    // every issue still unconsumed is in q (by issue cycle); delivery order is pc order.
    begin
      int          q[$];
      logic [31:0] next_issue, exp_pc, tgt, prev_pc;
      logic        rdy, rd, exp_valid, exp_issue, prev_hold;
      next_issue = RESET_PC;
      exp_pc     = RESET_PC;
      prev_hold  = 1'b0;
      prev_pc    = 32'h0;
      do_reset();
      for (int c = 0; c < 1000; c++) begin
        rd  = (c > 20) && ($urandom_range(0, 63) == 0);
        rdy = rd ? 1'b0 : 1'($urandom_range(0, 1));
        tgt = 32'($urandom_range(0, 1023)) << 2;
        step(c != 0, rdy, rd, tgt);
        exp_valid = (q.size() > 0) && ((c - q[0]) >= LAT);
        if (!rd) check($sformatf("rnd c%0d valid", c), 32'(bus.instr_valid_o), 32'(exp_valid));
        if (prev_hold) check($sformatf("rnd c%0d hold pc", c), bus.pc_o, prev_pc);
        exp_issue = (c > 0) && !rd && (q.size() < int'(DEPTH));
        check($sformatf("rnd c%0d op_en", c), 32'(bus.imem_op_en_o), 32'(exp_issue));
        if (bus.imem_op_en_o) check($sformatf("rnd c%0d addr", c), bus.imem_addr_o, next_issue);
        if (bus.instr_valid_o && rdy) begin
          check($sformatf("rnd c%0d pc", c), bus.pc_o, exp_pc);
          check($sformatf("rnd c%0d instr", c), bus.instr_o, ~exp_pc);
          exp_pc += 32'd4;
          if (q.size() > 0) void'(q.pop_front());
        end
        if (bus.imem_op_en_o) begin
          q.push_back(c);
          next_issue += 32'd4;
        end
        prev_hold = bus.instr_valid_o && !rdy && !rd;
        prev_pc   = bus.pc_o;
        if (rd) begin
          q.delete();
          next_issue = tgt;
          exp_pc     = tgt;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
